// File: rtl/rrs_pkg.sv
// Shared constants, entry-state type and CDB bus helper for the register result
// status table.
package rrs_pkg;

  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_TAG_W    = 3;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_NUM_CDB  = 1;

  // Widest tag and widest flattened CDB bus the helper and struct can carry.
  localparam int MAX_TAG_W    = 8;
  localparam int MAX_CDB_BITS = 64;

  typedef struct packed {
    logic                 busy;
    logic                 ready;
    logic [MAX_TAG_W-1:0] tag;
  } rrs_entry_t;

  // Tag of CDB port k from the packed bus, zero-extended to MAX_TAG_W.
  function automatic logic [MAX_TAG_W-1:0] cdb_port_tag(
    input logic [MAX_CDB_BITS-1:0] bus,
    input int                      k,
    input int                      tag_w
  );
    logic [MAX_TAG_W-1:0] mask;
    mask = MAX_TAG_W'((1 << tag_w) - 1);
    return MAX_TAG_W'(bus >> (k * tag_w)) & mask;
  endfunction

endpackage

// File: rtl/rrs_entry.sv
// One architectural-register status entry: busy/ready/tag state with the
// flush > alloc > commit > CDB update priority.
module rrs_entry
  import rrs_pkg::*;
#(
  parameter int TAG_W   = DEF_TAG_W,
  parameter int NUM_CDB = DEF_NUM_CDB
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     flush,
  input  logic                     alloc_hit,
  input  logic [TAG_W-1:0]         alloc_tag,
  input  logic                     commit_hit,
  input  logic [TAG_W-1:0]         commit_tag,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  output logic                     busy,
  output logic                     ready,
  output logic [TAG_W-1:0]         tag
);

  rrs_entry_t                state_q;
  rrs_entry_t                state_d;
  logic [MAX_CDB_BITS-1:0]   cdb_bus;
  logic                      cdb_hit;
  logic                      commit_match;

  assign cdb_bus      = MAX_CDB_BITS'(cdb_tag);
  assign commit_match = commit_hit && state_q.busy &&
                        (state_q.tag == MAX_TAG_W'(commit_tag));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    cdb_hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_valid[k] && (state_q.tag == cdb_port_tag(cdb_bus, k, TAG_W)))
        cdb_hit = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d.busy  = 1'b0;
      state_d.ready = 1'b0;
    end else if (alloc_hit) begin
      state_d.busy  = 1'b1;
      state_d.ready = 1'b0;
      state_d.tag   = MAX_TAG_W'(alloc_tag);
    end else if (commit_match) begin
      state_d.busy  = 1'b0;
      state_d.ready = 1'b0;
    end else if (state_q.busy && !state_q.ready && cdb_hit) begin
      state_d.ready = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every entry samples
  // the pre-edge values of its neighbours and inputs; the whole entry,
  // tag included, is reset so outputs read 0 during reset.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= '0;
    else        state_q <= state_d;
  end

  assign busy  = state_q.busy;
  assign ready = state_q.ready;
  assign tag   = state_q.tag[TAG_W-1:0];

endmodule

// File: rtl/reg_result_status_table.sv
// Register result status table: per-register busy/ready/tag with multi-CDB wakeup,
// commit release and flush. Define RRS_CDB_BYPASS_EN for same-cycle CDB ready bypass.
module reg_result_status_table
  import rrs_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int TAG_W    = DEF_TAG_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_CDB  = DEF_NUM_CDB,
  localparam int RW      = $clog2(NUM_REGS)
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     flush,
  input  logic                     alloc_valid,
  input  logic [RW-1:0]            alloc_reg,
  input  logic [TAG_W-1:0]         alloc_tag,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic                     commit_valid,
  input  logic [RW-1:0]            commit_reg,
  input  logic [TAG_W-1:0]         commit_tag,
  input  logic [NUM_RD*RW-1:0]     query_reg,
  output logic [NUM_RD-1:0]        query_busy,
  output logic [NUM_RD-1:0]        query_ready,
  output logic [NUM_RD*TAG_W-1:0]  query_tag,
  output logic [NUM_REGS-1:0]      busy_vec
);

  logic [NUM_REGS-1:0] alloc_hit;
  logic [NUM_REGS-1:0] commit_hit;
  logic [NUM_REGS-1:0] ent_ready;
  logic [TAG_W-1:0]    ent_tag [NUM_REGS];
  logic [RW-1:0]       qidx;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
    assign alloc_hit[i]  = alloc_valid  && (alloc_reg  == RW'(i));
    assign commit_hit[i] = commit_valid && (commit_reg == RW'(i));

    rrs_entry #(
      .TAG_W   (TAG_W),
      .NUM_CDB (NUM_CDB)
    ) u_entry (
      .CLK        (CLK),
      .Reset      (Reset),
      .flush      (flush),
      .alloc_hit  (alloc_hit[i]),
      .alloc_tag  (alloc_tag),
      .commit_hit (commit_hit[i]),
      .commit_tag (commit_tag),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .busy       (busy_vec[i]),
      .ready      (ent_ready[i]),
      .tag        (ent_tag[i])
    );
  end

`ifdef RRS_CDB_BYPASS_EN
  logic [MAX_CDB_BITS-1:0] cdb_bus;
  assign cdb_bus = MAX_CDB_BITS'(cdb_tag);
`endif

  always_comb begin
    query_busy  = '0;
    query_ready = '0;
    query_tag   = '0;
    qidx        = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      qidx                        = query_reg[p*RW +: RW];
      query_busy[p]               = busy_vec[qidx];
      query_ready[p]              = ent_ready[qidx];
      query_tag[p*TAG_W +: TAG_W] = ent_tag[qidx];
`ifdef RRS_CDB_BYPASS_EN
      // Forward a result broadcasting this cycle to the waiting consumer.
      for (int k = 0; k < NUM_CDB; k++) begin
        if (busy_vec[qidx] && cdb_valid[k] &&
            (MAX_TAG_W'(ent_tag[qidx]) == cdb_port_tag(cdb_bus, k, TAG_W)))
          query_ready[p] = 1'b1;
      end
`endif
    end
  end

endmodule
